// File: rtl/sequence_checker.sv
// Tracks the cyclic symbol sequence 2->5->3->1, locking after LOCK_CNT correct symbols.
// Outputs appear one cycle after the valid symbol is sampled; no backpressure.
module sequence_checker #(
   parameter int LOCK_CNT    = 4,
   parameter int UNLOCK_ERRS = 2
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       In_valid,
   input  logic [2:0] In,
   output logic       Locked,
   output logic       Err,
   output logic       Period_done,
   output logic [2:0] Expected,
   output logic [7:0] Err_count
);

   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] SYNC   = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [2:0] UNLOCK_N = 3'(UNLOCK_ERRS);

   logic [1:0] state;
   logic [3:0] good_cnt;
   logic [2:0] consec_err;

   function automatic logic [2:0] succ(input logic [2:0] s);
      case (s)
         3'd2:    succ = 3'd5;
         3'd5:    succ = 3'd3;
         3'd3:    succ = 3'd1;
         3'd1:    succ = 3'd2;
         default: succ = 3'd0;
      endcase
   endfunction

   function automatic logic is_member(input logic [2:0] s);
      is_member = (s == 3'd2) || (s == 3'd5) || (s == 3'd3) || (s == 3'd1);
   endfunction

   assign Locked = (state == LOCKED);

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state       <= HUNT;
         good_cnt    <= 4'd0;
         consec_err  <= 3'd0;
         Expected    <= 3'd0;
         Err         <= 1'b0;
         Period_done <= 1'b0;
         Err_count   <= 8'd0;
      end else begin
         Err         <= 1'b0;
         Period_done <= 1'b0;
         if (In_valid) begin
            case (state)
               HUNT: begin
                  if (is_member(In)) begin
                     state    <= SYNC;
                     good_cnt <= 4'd1;
                     Expected <= succ(In);
                  end
               end
               SYNC: begin
                  if (In == Expected) begin
                     good_cnt <= good_cnt + 4'd1;
                     Expected <= succ(In);
                     if (good_cnt + 4'd1 == LOCK_N) begin
                        state      <= LOCKED;
                        consec_err <= 3'd0;
                     end
                  end else if (is_member(In)) begin
                     good_cnt <= 4'd1;
                     Expected <= succ(In);
                  end else begin
                     state    <= HUNT;
                     good_cnt <= 4'd0;
                     Expected <= 3'd0;
                  end
               end
               LOCKED: begin
                  if (In == Expected) begin
                     consec_err  <= 3'd0;
                     Expected    <= succ(Expected);
                     Period_done <= (In == 3'd1);
                  end else begin
                     Err <= 1'b1;
                     if (Err_count != 8'hFF)
                        Err_count <= Err_count + 8'd1;
                     // Flywheel: keep predicting the sequence rather than realigning to the bad symbol.
                     if (consec_err + 3'd1 == UNLOCK_N) begin
                        state      <= HUNT;
                        good_cnt   <= 4'd0;
                        consec_err <= 3'd0;
                        Expected   <= 3'd0;
                     end else begin
                        consec_err <= consec_err + 3'd1;
                        Expected   <= succ(Expected);
                     end
                  end
               end
               default: begin
                  state    <= HUNT;
                  good_cnt <= 4'd0;
                  Expected <= 3'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with default parameters (LOCK_CNT=4, UNLOCK_ERRS=2).
module tb_sequence_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] in_sym;
   logic       locked;
   logic       err;
   logic       period_done;
   logic [2:0] expected;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;
   int model_cnt = 0;

   sequence_checker #(.LOCK_CNT(4), .UNLOCK_ERRS(2)) dut (
      .Clock       (clk),
      .Reset_n     (rst_n),
      .In_valid    (in_valid),
      .In          (in_sym),
      .Locked      (locked),
      .Err         (err),
      .Period_done (period_done),
      .Expected    (expected),
      .Err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [2:0] s);
      @(negedge clk);
      rst_n    = r;
      in_valid = v;
      in_sym   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] s);
      drive(1'b1, 1'b1, s);
   endtask

   task automatic bump();
      if (model_cnt < 255) model_cnt++;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sym = 3'd0;

      // Reset with valid traffic present
      drive(1'b0, 1'b1, 3'd2);
      drive(1'b0, 1'b1, 3'd5);
      chk("rst_locked", {7'd0, locked}, 8'd0);
      chk("rst_expected", {5'd0, expected}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
      chk("rst_pdone", {7'd0, period_done}, 8'd0);
      chk("rst_errcnt", err_count, 8'd0);

      // Acquire lock with 2,5,3,1
      send(3'd2); chk("acq2_exp", {5'd0, expected}, 8'd5); chk("acq2_lock", {7'd0, locked}, 8'd0);
      send(3'd5); chk("acq5_exp", {5'd0, expected}, 8'd3);
      send(3'd3); chk("acq3_exp", {5'd0, expected}, 8'd1); chk("acq3_lock", {7'd0, locked}, 8'd0);
      send(3'd1); chk("acq1_lock", {7'd0, locked}, 8'd1); chk("acq1_exp", {5'd0, expected}, 8'd2);
      chk("acq1_pdone", {7'd0, period_done}, 8'd0); chk("acq1_err", {7'd0, err}, 8'd0);

      // Idle cycle holds everything
      drive(1'b1, 1'b0, 3'd6);
      chk("idle_lock", {7'd0, locked}, 8'd1); chk("idle_exp", {5'd0, expected}, 8'd2);
      chk("idle_err", {7'd0, err}, 8'd0);

      // Three clean periods
      for (int r = 0; r < 3; r++) begin
         send(3'd2); chk("per_pd2", {7'd0, period_done}, 8'd0);
         send(3'd5); chk("per_pd5", {7'd0, period_done}, 8'd0);
         send(3'd3); chk("per_pd3", {7'd0, period_done}, 8'd0);
         send(3'd1); chk("per_pd1", {7'd0, period_done}, 8'd1);
      end
      chk("per_errcnt", err_count, 8'd0);

      // Single mismatch is flywheeled
      send(3'd2); chk("fly2_exp", {5'd0, expected}, 8'd5);
      send(3'd7); bump();
      chk("fly7_err", {7'd0, err}, 8'd1); chk("fly7_cnt", err_count, 8'd1);
      chk("fly7_exp", {5'd0, expected}, 8'd3); chk("fly7_lock", {7'd0, locked}, 8'd1);
      send(3'd3); chk("fly3_err", {7'd0, err}, 8'd0); chk("fly3_exp", {5'd0, expected}, 8'd1);
      send(3'd1); chk("fly1_lock", {7'd0, locked}, 8'd1); chk("fly1_exp", {5'd0, expected}, 8'd2);
      chk("fly1_pdone", {7'd0, period_done}, 8'd1);

      // Two consecutive mismatches unlock
      send(3'd6); bump();
      chk("ul1_err", {7'd0, err}, 8'd1); chk("ul1_lock", {7'd0, locked}, 8'd1);
      chk("ul1_exp", {5'd0, expected}, 8'd5);
      send(3'd6); bump();
      chk("ul2_err", {7'd0, err}, 8'd1); chk("ul2_lock", {7'd0, locked}, 8'd0);
      chk("ul2_exp", {5'd0, expected}, 8'd0); chk("ul2_cnt", err_count, 8'd3);

      // HUNT: non-member ignored
      send(3'd4); chk("hunt4_exp", {5'd0, expected}, 8'd0); chk("hunt4_lock", {7'd0, locked}, 8'd0);

      // Realignment in SYNC: 2,5,1,3,1
      send(3'd2); chk("ra2_exp", {5'd0, expected}, 8'd5);
      send(3'd5); chk("ra5_exp", {5'd0, expected}, 8'd3);
      send(3'd1); chk("ra1_exp", {5'd0, expected}, 8'd2); chk("ra1_err", {7'd0, err}, 8'd0);
      send(3'd3); chk("ra3_exp", {5'd0, expected}, 8'd1); chk("ra3_err", {7'd0, err}, 8'd0);
      send(3'd1); chk("raf_exp", {5'd0, expected}, 8'd2); chk("raf_lock", {7'd0, locked}, 8'd0);
      chk("raf_cnt", err_count, 8'd3);

      // Non-member in SYNC drops to HUNT without Err
      send(3'd0); chk("sync0_exp", {5'd0, expected}, 8'd0); chk("sync0_err", {7'd0, err}, 8'd0);

      // Saturate Err_count: 300 more mismatches via relock/unlock rounds
      for (int r = 0; r < 150; r++) begin
         send(3'd2); send(3'd5); send(3'd3); send(3'd1);
         chk("sat_lock", {7'd0, locked}, 8'd1);
         send(3'd6); bump();
         send(3'd6); bump();
         chk("sat_cnt", err_count, model_cnt[7:0]);
         chk("sat_unlock", {7'd0, locked}, 8'd0);
      end

      // Relock, then reset concurrent with a valid symbol
      send(3'd2); send(3'd5); send(3'd3); send(3'd1);
      chk("pre_rst_cnt", err_count, 8'd255); chk("pre_rst_lock", {7'd0, locked}, 8'd1);
      drive(1'b0, 1'b1, 3'd2);
      chk("mid_rst_cnt", err_count, 8'd0); chk("mid_rst_lock", {7'd0, locked}, 8'd0);
      chk("mid_rst_exp", {5'd0, expected}, 8'd0); chk("mid_rst_pdone", {7'd0, period_done}, 8'd0);

      // First symbol after reset follows HUNT rules
      send(3'd3); chk("post3_exp", {5'd0, expected}, 8'd1); chk("post3_lock", {7'd0, locked}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
